// File: rtl/scan_pkg.sv
// rtl/scan_pkg.sv - shared scan sequencer state and mode encodings
package scan_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } scan_state_e;

    localparam logic MODE_DUMP = 1'b0;
    localparam logic MODE_LOAD = 1'b1;

endpackage

// File: rtl/scan_snapshot_ctrl_if.sv
// rtl/scan_snapshot_ctrl_if.sv - host request/dump handshake bundle (dump_parity under SCAN_PARITY_EN)
interface scan_snapshot_ctrl_if #(
    parameter int CHAIN_LEN = 8
);
    logic                 req_valid;
    logic                 req_ready;
    logic                 req_load;
    logic [CHAIN_LEN-1:0] load_data;
    logic                 dump_valid;
    logic                 dump_ready;
    logic [CHAIN_LEN-1:0] dump_data;
`ifdef SCAN_PARITY_EN
    logic                 dump_parity;

    modport master (
        output req_valid, req_load, load_data, dump_ready,
        input  req_ready, dump_valid, dump_data, dump_parity
    );
    modport slave (
        input  req_valid, req_load, load_data, dump_ready,
        output req_ready, dump_valid, dump_data, dump_parity
    );
`else
    modport master (
        output req_valid, req_load, load_data, dump_ready,
        input  req_ready, dump_valid, dump_data
    );
    modport slave (
        input  req_valid, req_load, load_data, dump_ready,
        output req_ready, dump_valid, dump_data
    );
`endif
endinterface

// File: rtl/scan_shift_reg.sv
// rtl/scan_shift_reg.sv - parallel-load, serial-in right-shift register
module scan_shift_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift_en,
    input  logic             ser_in,
    input  logic [WIDTH-1:0] par_in,
    output logic [WIDTH-1:0] par_out,
    output logic             ser_out
);
    logic [WIDTH-1:0] sh_q;
    logic [WIDTH-1:0] sh_d;
    logic [WIDTH-1:0] shifted;

    generate
        if (WIDTH == 1) begin : g_one
            assign shifted = ser_in;
        end else begin : g_wide
            assign shifted = {ser_in, sh_q[WIDTH-1:1]};
        end
    endgenerate

    always_comb begin
        sh_d = sh_q;
        if (load) begin
            sh_d = par_in;
        end else if (shift_en) begin
            sh_d = shifted;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sh_q <= '0;
        end else begin
            sh_q <= sh_d;
        end
    end

    assign par_out = sh_q;
    assign ser_out = sh_q[0];
endmodule

// File: rtl/scan_snapshot_ctrl.sv
// rtl/scan_snapshot_ctrl.sv - scan chain dump/swap sequencer; SCAN_PARITY_EN adds dump_parity
module scan_snapshot_ctrl
    import scan_pkg::*;
#(
    parameter int CHAIN_LEN = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    scan_snapshot_ctrl_if.slave  host,
    output logic                 busy,
    output logic                 scan_en,
    output logic                 scan_si,
    input  logic                 scan_so
);
    localparam int CNT_W = $clog2(CHAIN_LEN + 1);

    scan_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mode_q, mode_d;
    logic             scan_en_q, scan_en_d;
    logic             sh_load;
    logic             sh_shift;
    logic             sh_ser_out;
    logic [CHAIN_LEN-1:0] sh_par_in;
    logic [CHAIN_LEN-1:0] sh_par_out;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mode_d   = mode_q;
        sh_load  = 1'b0;
        sh_shift = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (host.req_valid) begin
                    state_d = ST_SHIFT;
                    cnt_d   = '0;
                    mode_d  = host.req_load;
                    sh_load = 1'b1;
                end
            end
            ST_SHIFT: begin
                sh_shift = 1'b1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(CHAIN_LEN - 1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (host.dump_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // scan_en comes straight from a flop so the DUT never sees a decode glitch
        scan_en_d = (state_d == ST_SHIFT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            mode_q    <= MODE_DUMP;
            scan_en_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mode_q    <= mode_d;
            scan_en_q <= scan_en_d;
        end
    end

    assign sh_par_in = (host.req_load == MODE_LOAD) ? host.load_data : '0;

    scan_shift_reg #(.WIDTH(CHAIN_LEN)) u_shift (
        .clk      (clk),
        .rst      (rst),
        .load     (sh_load),
        .shift_en (sh_shift),
        .ser_in   (scan_so),
        .par_in   (sh_par_in),
        .par_out  (sh_par_out),
        .ser_out  (sh_ser_out)
    );

    // Dump mode feeds scan_out straight back so the chain rotates in place
    assign scan_si = scan_en_q ? ((mode_q == MODE_LOAD) ? sh_ser_out : scan_so) : 1'b0;
    assign scan_en = scan_en_q;

    assign busy            = (state_q != ST_IDLE);
    assign host.req_ready  = (state_q == ST_IDLE);
    assign host.dump_valid = (state_q == ST_DONE);
    assign host.dump_data  = sh_par_out;

`ifdef SCAN_PARITY_EN
    logic parity_q, parity_d;

    always_comb begin
        parity_d = parity_q;
        if (sh_load) begin
            parity_d = 1'b0;
        end else if (sh_shift) begin
            parity_d = parity_q ^ scan_so;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= parity_d;
        end
    end

    assign host.dump_parity = parity_q;
`endif
endmodule
